// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer_if
//  Brief    : Request/response and data-memory port bundle for store_buffer.
//             The slave side is the store buffer itself; the master side is
//             the execute stage together with the data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int AW = 6,
  parameter int DW = 32
) ();

  // Request channel from the execute stage
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  // Load response channel
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  // Data memory port (asynchronous read, synchronous write)
  logic [AW-1:0] mem_addr;
  logic          mem_MW;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_out;

  // Queue status
  logic          empty;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_out,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_MW, mem_data_in, empty
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_out,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_MW, mem_data_in, empty
  );

endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Brief    : Posted-write store buffer with a one-cycle load path. Stores are
//             queued in a circular FIFO and drained to data memory in cycles
//             with no accepted request; loads read memory combinationally and
//             are forwarded from the youngest matching queued store.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          reset,
  store_buffer_if.slave bus
);

  localparam int                 c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);

  // Queue storage and pointers
  logic [AW-1:0]      r_q_addr [DEPTH];
  logic [DW-1:0]      r_q_data [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_ptr_w:0]   r_count;

  // Registered load response
  logic               r_rsp_valid;
  logic [DW-1:0]      r_rsp_data;

  // Handshake and per-cycle decisions
  logic               w_ready;
  logic               w_accept;
  logic               w_enq;
  logic               w_load;
  logic               w_drain;

  // Forwarding network
  logic [DEPTH-1:0]   w_match;
  logic [c_ptr_w-1:0] w_idx;
  logic               w_fwd_hit;
  logic [DW-1:0]      w_fwd_data;

  // ready/empty depend on the occupancy count alone; a same-cycle drain
  // never opens a slot early, so a full queue always gets a drain cycle.
  assign w_ready  = (r_count < c_depth);
  assign w_accept = bus.req_valid & w_ready & reset;
  assign w_enq    = w_accept &  bus.req_we;
  assign w_load   = w_accept & ~bus.req_we;
  assign w_drain  = ~w_accept & (r_count != '0) & reset;

  assign bus.req_ready = w_ready;
  assign bus.empty     = (r_count == '0);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  // An entry is live when its distance from head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [c_ptr_w-1:0] w_age;
    assign w_age        = c_ptr_w'(gi) - r_head;
    assign w_match[gi]  = ({1'b0, w_age} < r_count) &&
                          (r_q_addr[gi] == bus.req_addr);
  end

  // Walk entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + c_ptr_w'(k);
      if (w_match[w_idx]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_q_data[w_idx];
      end
    end
  end

  // Memory port: loads take the port, otherwise drain the head entry,
  // otherwise park the port at zero.
  always_comb begin
    bus.mem_MW      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    if (w_load) begin
      bus.mem_addr = bus.req_addr;
    end else if (w_drain) begin
      bus.mem_MW      = 1'b1;
      bus.mem_addr    = r_q_addr[r_head];
      bus.mem_data_in = r_q_data[r_head];
    end
  end

  // Queue state: enqueue at tail on accepted stores, retire head on drains.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_q_addr[r_tail] <= bus.req_addr;
        r_q_data[r_tail] <= bus.req_wdata;
        r_tail           <= r_tail + c_ptr_one;
      end
      if (w_drain) begin
        r_head <= r_head + c_ptr_one;
      end
      if (w_enq) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_drain) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Load response: one-cycle valid pulse, data held until the next load.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_load;
      if (w_load) begin
        r_rsp_data <= w_fwd_hit ? w_fwd_data : bus.mem_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Brief    : Directed self-checking bench for store_buffer with a behavioural
//             64-word data memory and a log of every memory write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int AW = 6;
  localparam int DW = 32;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem [64];
  logic [AW-1:0] wlog_addr [$];
  logic [DW-1:0] wlog_data [$];

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Data memory: asynchronous read, synchronous write, every write logged.
  assign bus.mem_out = mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (bus.mem_MW === 1'b1) begin
      mem[bus.mem_addr] = bus.mem_data_in;
      wlog_addr.push_back(bus.mem_addr);
      wlog_data.push_back(bus.mem_data_in);
    end
  end

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, '0);
    #2;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h, expected 0", bus.rsp_data); end
    checks++; if (bus.mem_MW !== 1'b0) begin errors++; $display("FAIL reset_mem_MW: got %b, expected 0", bus.mem_MW); end
    checks++; if (bus.mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", bus.mem_addr); end
    checks++; if (bus.mem_data_in !== 32'h0) begin errors++; $display("FAIL reset_mem_data_in: got %h, expected 0", bus.mem_data_in); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, expected 1", bus.empty); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, expected 1", bus.req_ready); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_drain_order();
    clear_log();
    drive(1'b1, 1'b1, 6'd1, 32'h56); tick();
    drive(1'b1, 1'b1, 6'd2, 32'h25); tick();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    checks++; if ({bus.mem_MW, bus.mem_addr, bus.mem_data_in} !== {1'b1, 6'd1, 32'h56}) begin errors++; $display("FAIL drain_first: got MW=%b addr=%h data=%h, expected 1/01/56", bus.mem_MW, bus.mem_addr, bus.mem_data_in); end
    tick();
    checks++; if ({bus.mem_MW, bus.mem_addr, bus.mem_data_in} !== {1'b1, 6'd2, 32'h25}) begin errors++; $display("FAIL drain_second: got MW=%b addr=%h data=%h, expected 1/02/25", bus.mem_MW, bus.mem_addr, bus.mem_data_in); end
    tick();
    checks++; if ({bus.empty, bus.mem_MW, bus.mem_addr, bus.mem_data_in} !== {1'b1, 1'b0, 6'd0, 32'h0}) begin errors++; $display("FAIL drain_idle: got empty=%b MW=%b addr=%h data=%h, expected 1/0/00/0", bus.empty, bus.mem_MW, bus.mem_addr, bus.mem_data_in); end
    checks++; if (wlog_addr.size() !== 2) begin errors++; $display("FAIL drain_count: got %0d writes, expected 2", wlog_addr.size()); end
    drive(1'b1, 1'b0, 6'd1, '0); tick();
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h56}) begin errors++; $display("FAIL drain_load1: got v=%b data=%h, expected 1/56", bus.rsp_valid, bus.rsp_data); end
    drive(1'b1, 1'b0, 6'd2, '0); tick();
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h25}) begin errors++; $display("FAIL drain_load2: got v=%b data=%h, expected 1/25", bus.rsp_valid, bus.rsp_data); end
    drive(1'b0, 1'b0, '0, '0); tick();
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b0, 32'h25}) begin errors++; $display("FAIL rsp_pulse_hold: got v=%b data=%h, expected 0/25", bus.rsp_valid, bus.rsp_data); end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 1'b1, 6'd3, 32'h99); tick();
    drive(1'b1, 1'b0, 6'd3, '0);
    #1;
    checks++; if ({bus.mem_MW, bus.mem_addr} !== {1'b0, 6'd3}) begin errors++; $display("FAIL fwd_port: got MW=%b addr=%h, expected 0/03", bus.mem_MW, bus.mem_addr); end
    tick();
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h99}) begin errors++; $display("FAIL fwd_data: got v=%b data=%h, expected 1/99", bus.rsp_valid, bus.rsp_data); end
    drive(1'b0, 1'b0, '0, '0); tick();
    checks++; if ({bus.empty, mem[3]} !== {1'b1, 32'h99}) begin errors++; $display("FAIL fwd_drained: got empty=%b mem3=%h, expected 1/99", bus.empty, mem[3]); end
  endtask

  task automatic test_youngest();
    clear_log();
    drive(1'b1, 1'b1, 6'd5, 32'h11); tick();
    drive(1'b1, 1'b1, 6'd5, 32'h22); tick();
    drive(1'b1, 1'b0, 6'd5, '0); tick();
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h22}) begin errors++; $display("FAIL youngest_data: got v=%b data=%h, expected 1/22", bus.rsp_valid, bus.rsp_data); end
    drive(1'b0, 1'b0, '0, '0); tick(); tick();
    checks++; if (wlog_data.size() !== 2) begin errors++; $display("FAIL youngest_count: got %0d writes, expected 2", wlog_data.size()); end
    checks++; if ({wlog_data[0], wlog_data[1]} !== {32'h11, 32'h22}) begin errors++; $display("FAIL youngest_order: got %h then %h, expected 11 then 22", wlog_data[0], wlog_data[1]); end
    checks++; if (mem[5] !== 32'h22) begin errors++; $display("FAIL youngest_mem: got %h, expected 22", mem[5]); end
  endtask

  task automatic test_full();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'(40 + i), 32'(256 + i)); tick();
    end
    drive(1'b1, 1'b1, 6'd44, 32'h104);
    #1;
    checks++; if ({bus.req_ready, bus.mem_MW, bus.mem_addr} !== {1'b0, 1'b1, 6'd40}) begin errors++; $display("FAIL full_stall: got ready=%b MW=%b addr=%h, expected 0/1/28", bus.req_ready, bus.mem_MW, bus.mem_addr); end
    tick();
    checks++; if ({bus.req_ready, bus.mem_MW} !== {1'b1, 1'b0}) begin errors++; $display("FAIL full_reopen: got ready=%b MW=%b, expected 1/0", bus.req_ready, bus.mem_MW); end
    tick();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_again: got ready=%b, expected 0", bus.req_ready); end
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (wlog_addr.size() !== 5) begin errors++; $display("FAIL full_count: got %0d writes, expected 5", wlog_addr.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({wlog_addr[i], wlog_data[i]} !== {6'(40 + i), 32'(256 + i)}) begin errors++; $display("FAIL full_order[%0d]: got %h/%h, expected %h/%h", i, wlog_addr[i], wlog_data[i], 6'(40 + i), 32'(256 + i)); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b, expected 1", bus.empty); end
  endtask

  task automatic test_load_priority();
    clear_log();
    drive(1'b1, 1'b1, 6'd10, 32'hA); tick();
    drive(1'b1, 1'b1, 6'd11, 32'hB); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'd20, '0);
      #1;
      checks++; if ({bus.mem_MW, bus.mem_addr} !== {1'b0, 6'd20}) begin errors++; $display("FAIL prio_port[%0d]: got MW=%b addr=%h, expected 0/14", i, bus.mem_MW, bus.mem_addr); end
      tick();
      checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'hABCD}) begin errors++; $display("FAIL prio_data[%0d]: got v=%b data=%h, expected 1/abcd", i, bus.rsp_valid, bus.rsp_data); end
    end
    drive(1'b0, 1'b0, '0, '0);
    #1;
    checks++; if ({bus.mem_MW, bus.mem_addr} !== {1'b1, 6'd10}) begin errors++; $display("FAIL prio_resume: got MW=%b addr=%h, expected 1/0a", bus.mem_MW, bus.mem_addr); end
    tick(); tick();
    checks++; if (wlog_addr.size() !== 2) begin errors++; $display("FAIL prio_count: got %0d writes, expected 2", wlog_addr.size()); end
    checks++; if ({wlog_addr[0], wlog_addr[1]} !== {6'd10, 6'd11}) begin errors++; $display("FAIL prio_order: got %h then %h, expected 0a then 0b", wlog_addr[0], wlog_addr[1]); end
  endtask

  task automatic test_reset_midstream();
    clear_log();
    drive(1'b1, 1'b1, 6'd50, 32'h1); tick();
    drive(1'b1, 1'b1, 6'd51, 32'h2); tick();
    drive(1'b1, 1'b1, 6'd52, 32'h3); tick();
    drive(1'b1, 1'b0, 6'd20, '0); tick();
    checks++; if ({bus.rsp_valid, bus.empty} !== {1'b1, 1'b0}) begin errors++; $display("FAIL mid_before: got v=%b empty=%b, expected 1/0", bus.rsp_valid, bus.empty); end
    drive(1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (bus.mem_MW !== 1'b1) begin errors++; $display("FAIL mid_pending: got MW=%b, expected 1", bus.mem_MW); end
    reset = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.mem_MW, bus.empty, bus.req_ready} !== 4'b0011) begin errors++; $display("FAIL mid_reset: got v=%b MW=%b empty=%b ready=%b, expected 0/0/1/1", bus.rsp_valid, bus.mem_MW, bus.empty, bus.req_ready); end
    checks++; if ({bus.rsp_data, bus.mem_addr, bus.mem_data_in} !== {32'h0, 6'd0, 32'h0}) begin errors++; $display("FAIL mid_reset_zero: got data=%h addr=%h din=%h, expected 0/0/0", bus.rsp_data, bus.mem_addr, bus.mem_data_in); end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (wlog_addr.size() !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d writes, expected 0", wlog_addr.size()); end
    checks++; if ({bus.empty, mem[50]} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mid_discard: got empty=%b mem50=%h, expected 1/0", bus.empty, mem[50]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[20] = 32'hABCD;
    test_reset();
    test_drain_order();
    test_forwarding();
    test_youngest();
    test_full();
    test_load_priority();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer and load path between the execute stage and the 64-word data memory (`data_mem`). Stores are queued in a small FIFO and drained to the memory's write port in idle cycles. Loads read the memory with one-cycle latency, with forwarding from the youngest matching queued store. `data_mem` is treated as an asynchronous read (`out` = mem[`addr`]) and a synchronous write (rising `CLK` while `MW`=1).

## Interface
Parameters:
- `DEPTH`, 4: store queue entries; must be a power of 2, ≥2.
- `AW`, 6: address width (word address).
- `DW`, 32: data width.

Ports:
- `CLK` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: buffer can accept; equals (count < `DEPTH`).
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in `AW`: request word address.
- `req_wdata` in `DW`: store data; ignored for loads.
- `rsp_valid` out 1: load data valid; one-cycle pulse.
- `rsp_data` out `DW`: load result; holds last value.
- `mem_addr` out `AW`: to `data_mem.addr`.
- `mem_MW` out 1: to `data_mem.MW`.
- `mem_data_in` out `DW`: to `data_mem.data_in`.
- `mem_out` in `DW`: from `data_mem.out`.
- `empty` out 1: queue empty (count == 0).

## Operation
- **Storage:** circular FIFO of {addr, data} pairs with `head`/`tail` pointers of log2(`DEPTH`) bits. Pointers wrap naturally. `count` is log2(`DEPTH`)+1 bits.
- **Accept:** a request is accepted on a rising edge with `req_valid` & `req_ready`.
  - When full, `req_ready`=0 regardless of a same-cycle drain. There is no pass-through.
- **Store accepted:** write {`req_addr`, `req_wdata`} at `tail`; `tail`++. No response is produced.
- **Load accepted:**
  - Combinationally drive `mem_addr`=`req_addr`, `mem_MW`=0.
  - Forwarding: compare `req_addr` against every valid entry. The youngest match (closest to `tail`) supplies the data; otherwise use `mem_out`.
  - The result is registered into `rsp_data`, and `rsp_valid` is set for one cycle.
- **Drain:** occurs in any cycle with no accepted request and count > 0.
  - Drive `mem_MW`=1, `mem_addr`=head.addr, `mem_data_in`=head.data.
  - At the rising edge, memory writes and `head`++.
  - Incoming requests always have priority over drain. The full condition forces `req_ready` low, which guarantees drain progress.
- **Idle port:** `mem_MW`=0, `mem_addr`=0, `mem_data_in`=0.
- `mem_data_in` is nonzero only while draining.
- **Count update:** enqueue without drain gives +1, drain without enqueue gives −1. Both in the same cycle cannot occur, since drain requires no accepted request.
- **Reset** (`reset`=0, asynchronous):
  - `head`=`tail`=`count`=0, entries cleared.
  - Outputs: `rsp_valid`=0, `rsp_data`=0, `mem_MW`=0, `mem_addr`=0, `mem_data_in`=0, `empty`=1, `req_ready`=1.
  - Queued stores are discarded, with no further memory writes.
  - Release is synchronous to the next rising edge: first acceptance is possible on the first edge after `reset` returns high.

## Timing
- **Load latency:** accept at edge N; `rsp_valid`=1 and `rsp_data` valid from edge N until edge N+1. Back-to-back loads give back-to-back pulses.
- **Forwarding** covers stores accepted at any earlier edge, including edge N−1 (the store enqueued on the immediately preceding cycle).
- **Store visibility in memory:** the earliest write is at the first edge after acceptance with no accepted request.
- **Sustained stores:** `req_ready` drops the cycle after the `DEPTH`th undrained store. It rises again one edge after the next drain.
- `req_ready` and `empty` are combinational from `count` only. They do not depend on `req_valid`.
- All memory-port outputs are combinational from registered state plus `req_*`. `data_mem` samples them at the same rising edge.

## Test plan
- **Reset:** `reset`=0 mid-stream → immediately `rsp_valid`=0, `mem_MW`=0, `empty`=1, `req_ready`=1. With 3 stores queued at assertion, no `mem_MW` pulse follows release.
- **Drain order:** store (1, 0x56), store (2, 0x25), then idle → `mem_MW`=1 for two cycles: first addr 1/0x56, then addr 2/0x25. Then `empty`=1, and loading 1 and 2 returns 0x56 and 0x25.
- **Forwarding:** store (3, 0x99) immediately followed by load 3, memory[3]=0 → `rsp_data`=0x99 with `rsp_valid`=1 one cycle after the load.
- **Youngest match:** back-to-back store (5, 0x11), store (5, 0x22), load 5 → `rsp_data`=0x22. After drain, memory[5]=0x22, with writes observed in order 0x11 then 0x22.
- **Full / backpressure:** 5 consecutive store requests with `req_valid` held → first 4 accepted, `req_ready`=0 on cycle 5, then one drain (addr of the 1st store). The 5th is accepted the following edge, and total writes equal 5 in FIFO order.
- **Load miss, and load priority over drain:** with 2 stores queued (addrs 10, 11), continuous loads of addr 20 (memory 0xABCD) → `mem_MW` stays 0 while loads are accepted and every `rsp_data`=0xABCD. Drain resumes on the first idle cycle.
